// File: rtl/fb_pixel_writer.sv
// fb_pixel_writer: FIFO-buffered, fixed-timing pixel writer for the QSPI framebuffer; define FB_WRITER_PIXEL_CTR_EN to add the frame pixel counter
module fb_pixel_writer #(
   parameter int FIFO_DEPTH       = 4,
   parameter int SETUP_CYCLES     = 1,
   parameter int STROBE_CYCLES    = 4,
   parameter int GAP_CYCLES       = 4,
   parameter int PIXELS_PER_FRAME = 76800
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic [3:0]                            pixel_in,
   input  logic                                  frame_start_in,
   input  logic                                  pixel_valid_in,
   output logic                                  pixel_ready_out,
   output logic [3:0]                            write_data_out,
   output logic                                  write_strobe_out,
   output logic                                  reset_write_ptr_out,
   input  logic                                  wrote_data_in,
   output logic                                  busy_out,
   output logic                                  link_error_out,
   output logic                                  frame_done_out,
   output logic [$clog2(PIXELS_PER_FRAME+1)-1:0] pixel_count_out
);
   localparam int AW   = $clog2(FIFO_DEPTH);
   localparam int TMAX = STROBE_CYCLES > GAP_CYCLES
                         ? (STROBE_CYCLES > SETUP_CYCLES ? STROBE_CYCLES : SETUP_CYCLES)
                         : (GAP_CYCLES > SETUP_CYCLES ? GAP_CYCLES : SETUP_CYCLES);
   localparam int TW   = $clog2(TMAX + 1);
   localparam logic [TW-1:0] SET_L = TW'(SETUP_CYCLES - 1);
   localparam logic [TW-1:0] STR_L = TW'(STROBE_CYCLES - 1);
   localparam logic [TW-1:0] GAP_L = TW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {IDLE, PTR_RST, PTR_GAP, SETUP, STROBE, GAP} state_t;

   state_t        state_q, state_d;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [4:0]    mem_q [FIFO_DEPTH];
   logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
   logic [4:0]    head;
   logic          full, empty, push, pop, tdone, first_gap, last_gap;
   logic [3:0]    data_q, data_d;
   logic          strobe_q, strobe_d, ptr_q, ptr_d, busy_q, busy_d, err_q, err_d;

   assign full            = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign empty           = wr_q == rd_q;
   assign head            = mem_q[rd_q[AW-1:0]];
   assign push            = pixel_valid_in && !full;
   assign pop             = (state_q == IDLE) && !empty;
   assign wr_d            = wr_q + (AW+1)'(push);
   assign rd_d            = rd_q + (AW+1)'(pop);
   assign pixel_ready_out = !full;
   assign tdone           = tmr_q == '0;
   assign first_gap       = (state_q == GAP) && (tmr_q == GAP_L);
   assign last_gap        = (state_q == GAP) && tdone;

   // Pixel storage: {frame_start, pixel} per entry, no reset needed
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_q[AW-1:0]] <= {frame_start_in, pixel_in};
   end

   // FSM state and shared phase timer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // Next state: each timed phase loads the timer for the phase it enters
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q - TW'(1);
      case (state_q)
         IDLE: begin
            tmr_d = head[4] ? STR_L : SET_L;
            if (pop) state_d = head[4] ? PTR_RST : SETUP;
         end
         PTR_RST: if (tdone) begin state_d = PTR_GAP; tmr_d = GAP_L; end
         PTR_GAP: if (tdone) begin state_d = SETUP;   tmr_d = SET_L; end
         SETUP:   if (tdone) begin state_d = STROBE;  tmr_d = STR_L; end
         STROBE:  if (tdone) begin state_d = GAP;     tmr_d = GAP_L; end
         GAP:     if (tdone) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs decoded from the next state so the registered lines line up with the FSM
   always_comb begin
      data_d   = pop ? head[3:0] : data_q;
      strobe_d = state_d == STROBE;
      ptr_d    = state_d == PTR_RST;
      busy_d   = (state_d != IDLE) || (wr_d != rd_d);
      err_d    = err_q || (first_gap && !wrote_data_in) || (last_gap && wrote_data_in);
   end

   // FIFO pointers and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q     <= '0;
         rd_q     <= '0;
         data_q   <= '0;
         strobe_q <= 1'b0;
         ptr_q    <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         wr_q     <= wr_d;
         rd_q     <= rd_d;
         data_q   <= data_d;
         strobe_q <= strobe_d;
         ptr_q    <= ptr_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   assign write_data_out      = data_q;
   assign write_strobe_out    = strobe_q;
   assign reset_write_ptr_out = ptr_q;
   assign busy_out            = busy_q;
   assign link_error_out      = err_q;

`ifdef FB_WRITER_PIXEL_CTR_EN
   localparam int CW = $clog2(PIXELS_PER_FRAME + 1);
   logic          fs_q, done_q;
   logic [CW-1:0] cnt_q, cnt_inc;

   assign cnt_inc = fs_q ? CW'(1) : cnt_q + CW'(1);

   // Count finished pixels; reaching the frame size wraps to 0 with a one-cycle done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fs_q   <= 1'b0;
         done_q <= 1'b0;
         cnt_q  <= '0;
      end else begin
         if (pop) fs_q <= head[4];
         done_q <= last_gap && (cnt_inc == CW'(PIXELS_PER_FRAME));
         if (last_gap) cnt_q <= (cnt_inc == CW'(PIXELS_PER_FRAME)) ? '0 : cnt_inc;
      end
   end

   assign pixel_count_out = cnt_q;
   assign frame_done_out  = done_q;
`else
   assign pixel_count_out = '0;
   assign frame_done_out  = 1'b0;
`endif
endmodule

// File: tb/tb_fb_pixel_writer.sv
// tb_fb_pixel_writer: self-checking bench for fb_pixel_writer with a pixel-level reference model
module tb_fb_pixel_writer;
   localparam int DEPTH = 4, SET = 1, STR = 4, GAP = 4, PPF = 4;
   localparam int PER = 1 + SET + STR + GAP;
   localparam int CW = $clog2(PPF + 1);
`ifdef FB_WRITER_PIXEL_CTR_EN
   localparam bit CTR = 1'b1;
`else
   localparam bit CTR = 1'b0;
`endif

   logic          clk = 0, rst = 1, frame_start_in = 0, pixel_valid_in = 0, wrote_data_in = 0;
   logic [3:0]    pixel_in = 0;
   logic          pixel_ready_out, write_strobe_out, reset_write_ptr_out, busy_out, link_error_out, frame_done_out;
   logic [3:0]    write_data_out;
   logic [CW-1:0] pixel_count_out;
   bit            echo_en = 1;

   always #5 clk = ~clk;

   fb_pixel_writer #(.FIFO_DEPTH(DEPTH), .SETUP_CYCLES(SET), .STROBE_CYCLES(STR),
                     .GAP_CYCLES(GAP), .PIXELS_PER_FRAME(PPF)) dut (
      .clk(clk), .rst(rst), .pixel_in(pixel_in), .frame_start_in(frame_start_in),
      .pixel_valid_in(pixel_valid_in), .pixel_ready_out(pixel_ready_out),
      .write_data_out(write_data_out), .write_strobe_out(write_strobe_out),
      .reset_write_ptr_out(reset_write_ptr_out), .wrote_data_in(wrote_data_in),
      .busy_out(busy_out), .link_error_out(link_error_out), .frame_done_out(frame_done_out),
      .pixel_count_out(pixel_count_out));

   // scanout side: registered echo of the strobe
   always @(posedge clk) wrote_data_in <= echo_en & write_strobe_out;

   int cyc = 0, n_chk = 0, n_fail = 0;
   always @(posedge clk) cyc++;

   int         srise[$], prise[$], dchg[$], sw[$], pw[$];
   logic [3:0] wq[$];
   int         ovl, fd_hi, fd_pulse, erise, bfall, unstable, sw_cur, pw_cur;
   logic       ps = 0, pp = 0, pf = 0, pe = 0, pb = 0;
   logic [3:0] pd = 0;

   // observer: records write events on the framebuffer lines
   always @(negedge clk) begin
      if (write_strobe_out && !ps) begin srise.push_back(cyc); wq.push_back(write_data_out); sw_cur = 0; end
      if (write_strobe_out) sw_cur++;
      if (!write_strobe_out && ps) begin sw.push_back(sw_cur); if (write_data_out !== wq[$]) unstable++; end
      if (reset_write_ptr_out && !pp) begin prise.push_back(cyc); pw_cur = 0; end
      if (reset_write_ptr_out) pw_cur++;
      if (!reset_write_ptr_out && pp) pw.push_back(pw_cur);
      if (write_data_out !== pd) dchg.push_back(cyc);
      if (write_strobe_out && reset_write_ptr_out) ovl++;
      if (frame_done_out) fd_hi++;
      if (frame_done_out && !pf) fd_pulse++;
      if (link_error_out && !pe) erise = cyc;
      if (!busy_out && pb) bfall = cyc;
      ps = write_strobe_out; pp = reset_write_ptr_out; pf = frame_done_out;
      pe = link_error_out; pb = busy_out; pd = write_data_out;
   end

   function automatic int qi(input int q[$], input int i);
      return i < q.size() ? q[i] : -999;
   endfunction

   task automatic clr();
      srise.delete(); prise.delete(); dchg.delete(); sw.delete(); pw.delete(); wq.delete();
      ovl = 0; fd_hi = 0; fd_pulse = 0; erise = -1; bfall = -1; unstable = 0;
   endtask

   task automatic do_reset();
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0; echo_en = 1;
      #1 clr();
   endtask

   task automatic push_px(input logic [3:0] p, input logic fs, output int acc, output bit ok);
      pixel_in = p; frame_start_in = fs; pixel_valid_in = 1'b1; ok = 1'b0; acc = -1;
      for (int i = 0; i < 400 && !ok; i++) begin
         if (pixel_ready_out) begin ok = 1'b1; acc = cyc; end
         @(negedge clk);
      end
      pixel_valid_in = 1'b0;
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 600 && !ok; i++) begin @(negedge clk); ok = !busy_out; end
      #1;
   endtask

   task automatic test_reset();
      @(negedge clk); rst = 1; #1;
      n_chk++; if ({write_data_out, write_strobe_out, reset_write_ptr_out, busy_out, link_error_out, frame_done_out} !== 9'b0)
         begin n_fail++; $display("FAIL reset_outputs: got %b exp 0", {write_data_out, write_strobe_out, reset_write_ptr_out, busy_out, link_error_out, frame_done_out}); end
      n_chk++; if (pixel_ready_out !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b exp 1", pixel_ready_out); end
      n_chk++; if (pixel_count_out !== '0) begin n_fail++; $display("FAIL reset_count: got %0d exp 0", pixel_count_out); end
      @(negedge clk); rst = 0; #1 clr();
   endtask

   task automatic test_single();
      int acc; bit ok;
      do_reset();
      push_px(4'hA, 1'b0, acc, ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL single_accept: got 0 exp 1"); end
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL single_idle_timeout: got 0 exp 1"); end
      n_chk++; if (wq.size() != 1 || wq[0] !== 4'hA) begin n_fail++; $display("FAIL single_data: got %0d writes first %h exp 1 write of a", wq.size(), wq[0]); end
      n_chk++; if (qi(dchg, 0) != acc + 2) begin n_fail++; $display("FAIL single_data_latency: got %0d exp %0d", qi(dchg, 0), acc + 2); end
      n_chk++; if (qi(srise, 0) - qi(dchg, 0) != SET) begin n_fail++; $display("FAIL single_setup: got %0d exp %0d", qi(srise, 0) - qi(dchg, 0), SET); end
      n_chk++; if (qi(sw, 0) != STR) begin n_fail++; $display("FAIL single_strobe_width: got %0d exp %0d", qi(sw, 0), STR); end
      n_chk++; if (bfall != acc + 1 + PER) begin n_fail++; $display("FAIL single_period: got %0d exp %0d", bfall, acc + 1 + PER); end
      n_chk++; if (link_error_out !== 1'b0) begin n_fail++; $display("FAIL single_link_error: got %b exp 0", link_error_out); end
      n_chk++; if (pixel_count_out !== CW'(CTR ? 1 : 0)) begin n_fail++; $display("FAIL single_count: got %0d exp %0d", pixel_count_out, CTR ? 1 : 0); end
   endtask

   task automatic test_frame_start();
      int acc; bit ok;
      do_reset();
      push_px(4'h3, 1'b1, acc, ok);
      wait_idle(ok);
      n_chk++; if (!ok) begin n_fail++; $display("FAIL fs_idle_timeout: got 0 exp 1"); end
      n_chk++; if (prise.size() != 1 || qi(prise, 0) != acc + 2) begin n_fail++; $display("FAIL fs_ptr_start: got %0d exp %0d", qi(prise, 0), acc + 2); end
      n_chk++; if (qi(pw, 0) != STR) begin n_fail++; $display("FAIL fs_ptr_width: got %0d exp %0d", qi(pw, 0), STR); end
      n_chk++; if (qi(srise, 0) - qi(prise, 0) != STR + GAP + SET) begin n_fail++; $display("FAIL fs_ptr_to_strobe: got %0d exp %0d", qi(srise, 0) - qi(prise, 0), STR + GAP + SET); end
      n_chk++; if (wq.size() != 1 || wq[0] !== 4'h3) begin n_fail++; $display("FAIL fs_data: got %0d writes first %h exp 1 write of 3", wq.size(), wq[0]); end
      n_chk++; if (ovl != 0) begin n_fail++; $display("FAIL fs_overlap: got %0d exp 0", ovl); end
      n_chk++; if (pixel_count_out !== CW'(CTR ? 1 : 0)) begin n_fail++; $display("FAIL fs_count: got %0d exp %0d", pixel_count_out, CTR ? 1 : 0); end
   endtask

   task automatic test_back_to_back();
      int lvl = 0, free_at = 0, first_drop = -1, idx = 0; bit ok, rdy_exp, acc_now, pop_now;
      do_reset();
      pixel_valid_in = 1'b1; frame_start_in = 1'b0;
      for (int c = 0; c < 400 && idx < 8; c++) begin
         pixel_in = 4'(idx);
         rdy_exp = lvl < DEPTH;
         n_chk++; if (pixel_ready_out !== rdy_exp) begin n_fail++; $display("FAIL b2b_ready cyc %0d: got %b exp %b", cyc, pixel_ready_out, rdy_exp); end
         acc_now = pixel_ready_out;
         if (acc_now) idx++; else if (first_drop < 0) first_drop = idx;
         pop_now = lvl > 0 && cyc >= free_at;
         if (pop_now) free_at = cyc + PER;
         lvl += int'(acc_now) - int'(pop_now);
         @(negedge clk);
      end
      pixel_valid_in = 1'b0;
      wait_idle(ok);
      n_chk++; if (!ok || idx != 8) begin n_fail++; $display("FAIL b2b_timeout: got %0d accepted exp 8", idx); end
      n_chk++; if (first_drop != DEPTH + 1) begin n_fail++; $display("FAIL b2b_ready_drop: got %0d exp %0d", first_drop, DEPTH + 1); end
      n_chk++; if (wq.size() != 8) begin n_fail++; $display("FAIL b2b_write_count: got %0d exp 8", wq.size()); end
      for (int i = 0; i < 8 && i < wq.size(); i++) begin
         n_chk++; if (wq[i] !== 4'(i)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %0d exp %0d", i, wq[i], i); end
      end
      for (int i = 1; i < srise.size(); i++) begin
         n_chk++; if (srise[i] - srise[i-1] != PER) begin n_fail++; $display("FAIL b2b_period[%0d]: got %0d exp %0d", i, srise[i] - srise[i-1], PER); end
      end
      foreach (sw[i]) begin
         n_chk++; if (sw[i] != STR) begin n_fail++; $display("FAIL b2b_width[%0d]: got %0d exp %0d", i, sw[i], STR); end
      end
      n_chk++; if (unstable != 0) begin n_fail++; $display("FAIL b2b_data_stable: got %0d exp 0", unstable); end
      n_chk++; if (link_error_out !== 1'b0) begin n_fail++; $display("FAIL b2b_link_error: got %b exp 0", link_error_out); end
      n_chk++; if (fd_pulse != (CTR ? 8 / PPF : 0)) begin n_fail++; $display("FAIL b2b_frames: got %0d exp %0d", fd_pulse, CTR ? 8 / PPF : 0); end
      n_chk++; if (pixel_count_out !== CW'(CTR ? 8 % PPF : 0)) begin n_fail++; $display("FAIL b2b_count: got %0d exp %0d", pixel_count_out, CTR ? 8 % PPF : 0); end
   endtask

   task automatic test_link_error();
      int acc, lo; bit ok;
      do_reset();
      echo_en = 0;
      push_px(4'h9, 1'b0, acc, ok);
      for (int i = 0; i < 50 && !write_strobe_out; i++) @(negedge clk);
      n_chk++; if (link_error_out !== 1'b0) begin n_fail++; $display("FAIL echo_err_early: got %b exp 0", link_error_out); end
      wait_idle(ok);
      lo = qi(srise, 0) + STR;
      n_chk++; if (erise < lo || erise > lo + 1) begin n_fail++; $display("FAIL echo_err_time: got %0d exp %0d..%0d", erise, lo, lo + 1); end
      echo_en = 1;
      push_px(4'h6, 1'b0, acc, ok);
      wait_idle(ok);
      n_chk++; if (link_error_out !== 1'b1) begin n_fail++; $display("FAIL echo_err_sticky: got %b exp 1", link_error_out); end
      n_chk++; if (wq.size() != 2 || wq[0] !== 4'h9 || wq[1] !== 4'h6) begin n_fail++; $display("FAIL echo_writes: got %0d writes exp 9,6", wq.size()); end
   endtask

   task automatic test_reset_mid_strobe();
      int acc; bit ok;
      do_reset();
      for (int i = 0; i < 4; i++) push_px(4'(4'hC + i), 1'b0, acc, ok);
      for (int i = 0; i < 50 && !write_strobe_out; i++) @(negedge clk);
      @(negedge clk); rst = 1; #1;
      n_chk++; if ({write_data_out, write_strobe_out, reset_write_ptr_out, busy_out, link_error_out, frame_done_out} !== 9'b0)
         begin n_fail++; $display("FAIL midrst_outputs: got %b exp 0", {write_data_out, write_strobe_out, reset_write_ptr_out, busy_out, link_error_out, frame_done_out}); end
      n_chk++; if (pixel_ready_out !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b exp 1", pixel_ready_out); end
      @(negedge clk); rst = 0; #1 clr();
      repeat (3 * PER) @(negedge clk);
      #1;
      n_chk++; if (wq.size() != 0 || busy_out !== 1'b0) begin n_fail++; $display("FAIL midrst_fifo_empty: got %0d writes busy %b exp 0 0", wq.size(), busy_out); end
      push_px(4'h5, 1'b0, acc, ok);
      wait_idle(ok);
      n_chk++; if (wq.size() != 1 || wq[0] !== 4'h5 || qi(sw, 0) != STR) begin n_fail++; $display("FAIL midrst_new_pixel: got %0d writes width %0d exp 1 write of 5 width %0d", wq.size(), qi(sw, 0), STR); end
      n_chk++; if (pixel_count_out !== CW'(CTR ? 1 : 0)) begin n_fail++; $display("FAIL midrst_count: got %0d exp %0d", pixel_count_out, CTR ? 1 : 0); end
   endtask

   task automatic test_frame_done();
      int acc; bit ok;
      do_reset();
      push_px(4'h1, 1'b1, acc, ok);
      for (int i = 2; i <= PPF; i++) push_px(4'(i), 1'b0, acc, ok);
      wait_idle(ok);
      n_chk++; if (fd_pulse != (CTR ? 1 : 0)) begin n_fail++; $display("FAIL frame_done_pulses: got %0d exp %0d", fd_pulse, CTR ? 1 : 0); end
      n_chk++; if (fd_hi != fd_pulse) begin n_fail++; $display("FAIL frame_done_width: got %0d high cycles exp %0d", fd_hi, fd_pulse); end
      n_chk++; if (pixel_count_out !== '0) begin n_fail++; $display("FAIL frame_done_count: got %0d exp 0", pixel_count_out); end
   endtask

   task automatic test_random();
      logic [3:0] exp_q[$]; int acc, mcnt = 0, mdone = 0, nfs = 0; bit ok; logic [3:0] p; logic fs;
      do_reset();
      for (int k = 0; k < 16; k++) begin
         p = 4'($urandom_range(0, 15)); fs = ($urandom_range(0, 3) == 0);
         push_px(p, fs, acc, ok);
         exp_q.push_back(p);
         nfs += int'(fs);
         mcnt = fs ? 1 : mcnt + 1;
         if (mcnt == PPF) begin mcnt = 0; mdone++; end
         repeat ($urandom_range(0, 12)) @(negedge clk);
      end
      wait_idle(ok);
      n_chk++; if (wq.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_write_count: got %0d exp %0d", wq.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
         n_chk++; if (wq[i] !== exp_q[i]) begin n_fail++; $display("FAIL rand_data[%0d]: got %h exp %h", i, wq[i], exp_q[i]); end
      end
      n_chk++; if (prise.size() != nfs) begin n_fail++; $display("FAIL rand_ptr_resets: got %0d exp %0d", prise.size(), nfs); end
      n_chk++; if (ovl != 0) begin n_fail++; $display("FAIL rand_overlap: got %0d exp 0", ovl); end
      n_chk++; if (fd_pulse != (CTR ? mdone : 0)) begin n_fail++; $display("FAIL rand_frames: got %0d exp %0d", fd_pulse, CTR ? mdone : 0); end
      n_chk++; if (pixel_count_out !== CW'(CTR ? mcnt : 0)) begin n_fail++; $display("FAIL rand_count: got %0d exp %0d", pixel_count_out, CTR ? mcnt : 0); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_frame_start();
      test_back_to_back();
      test_link_error();
      test_reset_mid_strobe();
      test_frame_done();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end
endmodule

// File: doc/fb_pixel_writer.md
# fb_pixel_writer

Write-side driver for the QSPI framebuffer shared with the VGA scanout. Accepts 4-bit gray pixels from the Mandelbrot iteration engine over a valid/ready handshake, buffers them in a small FIFO, and paces them onto the framebuffer write lines (data nibble, write strobe, write-pointer reset) with fixed setup/strobe/gap timing so the RP2040 side can sample them. Checks the scanout block's registered strobe echo to detect a broken link.

## Interface
- FIFO_DEPTH, 4: pixel FIFO entries; power of two, ≥2.
- SETUP_CYCLES, 1: cycles data is stable before the strobe rises; ≥1.
- STROBE_CYCLES, 4: strobe / pointer-reset high time; ≥2.
- GAP_CYCLES, 4: low time after each strobe; ≥2.
- PIXELS_PER_FRAME, 76800: pixels per frame, 320×240.

- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- pixel_in  in  4  gray pixel value
- frame_start_in  in  1  marks the pixel as the first of a frame; sampled with pixel_in
- pixel_valid_in  in  1  pixel offered
- pixel_ready_out  out  1  FIFO not full; transfer when valid && ready
- write_data_out  out  4  nibble to the framebuffer
- write_strobe_out  out  1  write strobe
- reset_write_ptr_out  out  1  framebuffer write-pointer reset pulse
- wrote_data_in  in  1  registered strobe echo from the scanout block
- busy_out  out  1  FSM not in IDLE, or FIFO non-empty
- link_error_out  out  1  sticky echo-mismatch flag
- frame_done_out  out  1  one-cycle pulse after the last pixel of a frame
- pixel_count_out  out  clog2(PIXELS_PER_FRAME+1)  pixels written in the current frame

## Operation
- FIFO entries are 5 bits: {frame_start, pixel}.
- pixel_ready_out is !full, combinational from registered pointers. No push when full, even if a pop happens in the same cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: both happen and the level is unchanged.
- FSM states: IDLE, PTR_RST, PTR_GAP, SETUP, STROBE, GAP. One down-counter is shared by all timed states.
- IDLE with FIFO non-empty:
  - pop the head; write_data_out <= pixel.
  - if frame_start is set, go to PTR_RST; otherwise go to SETUP.
- PTR_RST: reset_write_ptr_out=1 for STROBE_CYCLES, then PTR_GAP.
- PTR_GAP: all strobes low for GAP_CYCLES, then SETUP.
- SETUP: strobe low for SETUP_CYCLES, then STROBE.
- STROBE: write_strobe_out=1 for STROBE_CYCLES, then GAP.
- GAP: strobe low for GAP_CYCLES, then IDLE.
- write_data_out holds from pop until the next pop.
- Echo check:
  - in the first GAP cycle, wrote_data_in must be 1; in the last GAP cycle it must be 0.
  - on any violation, link_error_out is set and stays set until rst.
  - pixels continue to be written after an error.
- Pixel counter:
  - at the last GAP cycle, the count increments; a frame_start pixel loads 1 instead.
  - on reaching PIXELS_PER_FRAME, frame_done_out pulses in the next cycle and the count returns to 0.
  - overflow without frame_start wraps the same way.
- Reset is asynchronous and may arrive mid-write:
  - all outputs go to 0 immediately except pixel_ready_out, which is 1.
  - FIFO empties, FSM goes to IDLE, counter clears, link_error_out clears.
  - the interrupted pixel is lost.

## Timing
- All outputs are registered except pixel_ready_out.
- Accept to pop: a pixel accepted in cycle n into an empty FIFO with the FSM in IDLE pops in cycle n+1; write_data_out is valid from n+2.
- Strobe rises SETUP_CYCLES after write_data_out changes and stays high for exactly STROBE_CYCLES.
- Per-pixel period is 1+SETUP+STROBE+GAP cycles, 10 at defaults.
- A frame-start pixel adds STROBE_CYCLES+GAP_CYCLES.
- write_strobe_out and reset_write_ptr_out are never high together.
- The scanout echo lags write_strobe_out by exactly 1 cycle.

## Configuration
- FB_WRITER_PIXEL_CTR_EN
  - defined: pixel counter, frame_done_out and wrap behaviour as above.
  - undefined: counter logic is removed; pixel_count_out and frame_done_out are constant 0. All other behaviour is identical.

## Test plan
- Reset, then a single pixel 0xA with no frame_start:
  - write_data_out=0xA; strobe high 4 cycles, starting 1 cycle after data; 10-cycle period.
  - with the echo loopback modelled, link_error_out stays 0.
- Pixel 0x3 with frame_start=1:
  - reset_write_ptr_out high 4 cycles, low 4 cycles, then a normal write of 0x3.
  - pixel_count_out=1 afterwards.
- valid held high with 8 pixels, 0..7:
  - ready drops after 4 FIFO entries plus 1 in flight.
  - all 8 nibbles are written in order with no loss or duplication.
  - ready never goes high while full.
- Echo tied to 0:
  - link_error_out sets at the first GAP cycle of the first pixel and remains 1 for later pixels.
- rst asserted mid-STROBE with 3 pixels queued:
  - strobe goes to 0 asynchronously; FIFO empties; busy_out=0 and ready=1.
  - a new pixel after release writes normally.
- Macro defined, PIXELS_PER_FRAME=4:
  - after 4 pixels, frame_done_out pulses once and the count returns to 0.
  - with the macro undefined, frame_done_out is never 1.
